// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-ported memory with combinational read data between the
// instruction-fetch master and the data master of the CPU. Requests are
// granted round-robin. Each transfer passes through IDLE -> WAIT -> DONE, and
// LATENCY wait states are inserted to emulate slow memory.
//
// Parameters
//   LATENCY        wait-state cycles between grant and completion (0..15)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   i_read         instruction fetch request
//   i_address      fetch byte address
//   i_readdata     fetch data, valid when i_read && !i_waitrequest
//   i_waitrequest  instruction master stall
//   d_read         data read request
//   d_write        data write request (wins over d_read when both are high)
//   d_address      data byte address
//   d_writedata    write data
//   d_byteenable   byte lanes for read/write
//   d_readdata     data read result, valid when d_read && !d_waitrequest
//   d_waitrequest  data master stall
//   m_address      memory address (granted master's, else 0)
//   m_read         memory read strobe (WAIT and DONE of a read)
//   m_write        memory write strobe (DONE of a write only)
//   m_writedata    memory write data
//   m_byteenable   memory byte lanes (4'hF for fetches)
//   m_readdata     memory combinational read data
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic [31:0] m_readdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic       GRANT_INSTR = 1'b0;
    localparam logic       GRANT_DATA  = 1'b1;
    localparam logic [3:0] LAT_CNT     = 4'(LATENCY);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic        grant_r;
    logic        grant_s;
    logic        last_grant_r;
    logic        last_grant_s;
    logic [31:0] i_rdata_r;
    logic [31:0] d_rdata_r;

    logic        i_req_s;
    logic        d_req_s;
    logic        gnt_req_s;
    logic        active_s;
    logic        done_s;
    logic        i_done_s;
    logic        d_done_s;
    logic        d_is_write_s;

    // Request decode; the granted master's request is re-checked every cycle
    // so that a dropped request aborts the transfer instead of completing it.
    always_comb begin
        i_req_s      = i_read;
        d_req_s      = d_read | d_write;
        d_is_write_s = d_write;
        if (grant_r == GRANT_DATA) begin
            gnt_req_s = d_req_s;
        end else begin
            gnt_req_s = i_req_s;
        end
        active_s = ((state_r == ST_WAIT) || (state_r == ST_DONE)) && gnt_req_s;
        done_s   = (state_r == ST_DONE) && gnt_req_s;
        i_done_s = done_s && (grant_r == GRANT_INSTR);
        d_done_s = done_s && (grant_r == GRANT_DATA);
    end

    // Next-state logic: round-robin grant in IDLE, wait-state countdown, abort on dropped request.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (i_req_s || d_req_s) begin
                    if (i_req_s && d_req_s) begin
                        // Tie: the master that was not served last goes first.
                        if (last_grant_r == GRANT_DATA) begin
                            grant_s = GRANT_INSTR;
                        end else begin
                            grant_s = GRANT_DATA;
                        end
                    end else if (i_req_s) begin
                        grant_s = GRANT_INSTR;
                    end else begin
                        grant_s = GRANT_DATA;
                    end
                    cnt_s = LAT_CNT;
                    if (LAT_CNT == 4'd0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!gnt_req_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end else if (cnt_r <= 4'd1) begin
                    // The final wait-state cycle; the counter lands on zero.
                    state_s = ST_DONE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
                if (gnt_req_s) begin
                    last_grant_s = grant_r;
                end else begin
                    last_grant_s = last_grant_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM, counter and grant registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            grant_r      <= GRANT_INSTR;
            last_grant_r <= GRANT_DATA;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
        end
    end

    // Holding registers that keep each master's last read result between transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rdata_r <= 32'h0000_0000;
            d_rdata_r <= 32'h0000_0000;
        end else begin
            if (i_done_s) begin
                i_rdata_r <= m_readdata;
            end
            if (d_done_s && !d_is_write_s) begin
                d_rdata_r <= m_readdata;
            end
        end
    end

    // Memory-side and master-side output decode from the registered state.
    always_comb begin
        m_address     = 32'h0000_0000;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = 32'h0000_0000;
        m_byteenable  = 4'h0;
        i_waitrequest = !i_done_s;
        d_waitrequest = !d_done_s;
        if (active_s) begin
            if (grant_r == GRANT_DATA) begin
                m_address    = d_address;
                m_byteenable = d_byteenable;
                m_read       = !d_is_write_s;
                if (d_is_write_s) begin
                    m_writedata = d_writedata;
                end else begin
                    m_writedata = 32'h0000_0000;
                end
                // Writes strobe only in DONE so a late abort never commits.
                m_write = done_s && d_is_write_s;
            end else begin
                m_address    = i_address;
                m_byteenable = 4'hF;
                m_read       = 1'b1;
            end
        end else begin
            m_address = 32'h0000_0000;
        end
        if (i_done_s) begin
            i_readdata = m_readdata;
        end else begin
            i_readdata = i_rdata_r;
        end
        if (d_done_s && !d_is_write_s) begin
            d_readdata = m_readdata;
        end else begin
            d_readdata = d_rdata_r;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    localparam int LAT = 2;

    localparam logic [31:0] INIT [16] = '{
        32'h8C02_0000, 32'h2442_0001, 32'hAC02_0004, 32'h1000_FFFD,
        32'h0000_0000, 32'hCAFE_F00D, 32'h1234_5678, 32'h9ABC_DEF0,
        32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h5555_AAAA, 32'hAAAA_5555,
        32'h0102_0304, 32'hA5A5_5A5A, 32'h7777_8888, 32'hFFFF_0001
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic [31:0] m_readdata;

    logic [31:0] ram [16] = INIT;
    logic [31:0] mdl [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
        .i_waitrequest(i_waitrequest),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_readdata(m_readdata)
    );

    // RAM model: combinational read, byte-lane write on the clock edge.
    assign m_readdata = ram[m_address[5:2]];
    always @(posedge clk) begin
        if (m_write) begin
            for (int b = 0; b < 4; b++) begin
                if (m_byteenable[b]) ram[m_address[5:2]][8*b +: 8] <= m_writedata[8*b +: 8];
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        i_read = 1'b0; i_address = 32'h0; d_read = 1'b0; d_write = 1'b0;
        d_address = 32'h0; d_writedata = 32'h0; d_byteenable = 4'h0;
    endtask

    // Leaves time just after a rising edge with reset released and the arbiter idle.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_fetch();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin i_read = 1'b1; i_address = 32'hBFC0_0000; end
            if (c == 4) i_read = 1'b0;
            @(negedge clk);
            checks++; if (i_waitrequest !== (c != 3)) begin errors++; $display("FAIL fetch_wait c=%0d got %b exp %b", c, i_waitrequest, (c != 3)); end
            checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL fetch_dwait c=%0d got %b exp 1", c, d_waitrequest); end
            checks++; if (m_read !== (c >= 1 && c <= 3)) begin errors++; $display("FAIL fetch_mread c=%0d got %b exp %b", c, m_read, (c >= 1 && c <= 3)); end
            if (c >= 1 && c <= 3) begin
                checks++; if (m_address !== 32'hBFC0_0000 || m_byteenable !== 4'hF) begin errors++; $display("FAIL fetch_maddr c=%0d got %h/%h exp bfc00000/f", c, m_address, m_byteenable); end
            end
            if (c >= 3) begin
                checks++; if (i_readdata !== 32'h8C02_0000) begin errors++; $display("FAIL fetch_data c=%0d got %h exp 8c020000", c, i_readdata); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait got %b%b exp 11", i_waitrequest, d_waitrequest); end
        checks++; if (m_read !== 1'b0 || m_write !== 1'b0 || m_byteenable !== 4'h0) begin errors++; $display("FAIL reset_mem got r%b w%b be%h exp r0 w0 be0", m_read, m_write, m_byteenable); end
        checks++; if (m_address !== 32'h0 || m_writedata !== 32'h0) begin errors++; $display("FAIL reset_bus got %h/%h exp 0/0", m_address, m_writedata); end
        checks++; if (i_readdata !== 32'h0 || d_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", i_readdata, d_readdata); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (i_waitrequest !== 1'b1 || d_waitrequest !== 1'b1 || m_read !== 1'b0) begin errors++; $display("FAIL reset_after got %b%b%b exp 110", i_waitrequest, d_waitrequest, m_read); end
        @(posedge clk); #1;
    endtask

    task automatic test_tie_write();
        int nw;
        nw = 0;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c == 0) begin
                i_read = 1'b1; i_address = 32'hBFC0_0000;
                d_write = 1'b1; d_address = 32'h0000_0100; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
            end
            if (c == 4) i_read = 1'b0;
            if (c == 8) begin d_write = 1'b0; d_read = 1'b1; d_byteenable = 4'hF; end
            if (c == 12) d_read = 1'b0;
            @(negedge clk);
            if (m_write === 1'b1) nw++;
            checks++; if (i_waitrequest !== (c != 3)) begin errors++; $display("FAIL tie_iwait c=%0d got %b exp %b", c, i_waitrequest, (c != 3)); end
            checks++; if (d_waitrequest !== !(c == 7 || c == 11)) begin errors++; $display("FAIL tie_dwait c=%0d got %b exp %b", c, d_waitrequest, !(c == 7 || c == 11)); end
            checks++; if (m_write !== (c == 7)) begin errors++; $display("FAIL tie_mwrite c=%0d got %b exp %b", c, m_write, (c == 7)); end
            if (c == 7) begin
                checks++; if (m_byteenable !== 4'b0011 || m_address !== 32'h100 || m_writedata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tie_wbus got %h/%h/%h exp 3/100/deadbeef", m_byteenable, m_address, m_writedata); end
                checks++; if (d_readdata !== 32'h0) begin errors++; $display("FAIL tie_wrdata got %h exp 0", d_readdata); end
            end
            if (c == 11) begin
                checks++; if (d_readdata !== 32'h8C02_BEEF) begin errors++; $display("FAIL tie_readback got %h exp 8c02beef", d_readdata); end
            end
            @(posedge clk); #1;
        end
        mdl[0] = merge(mdl[0], 32'hDEAD_BEEF, 4'b0011);
        checks++; if (nw !== 1) begin errors++; $display("FAIL tie_wcount got %0d exp 1", nw); end
    endtask

    task automatic test_alternate();
        do_reset();
        i_read = 1'b1; i_address = 32'h0000_0004;
        d_read = 1'b1; d_address = 32'h0000_0008; d_byteenable = 4'hF;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++; if (i_waitrequest !== !((c % 4 == 3) && ((c / 4) % 2 == 0))) begin errors++; $display("FAIL alt_i c=%0d got %b", c, i_waitrequest); end
            checks++; if (d_waitrequest !== !((c % 4 == 3) && ((c / 4) % 2 == 1))) begin errors++; $display("FAIL alt_d c=%0d got %b", c, d_waitrequest); end
            if (c % 4 == 3) begin
                checks++; if (i_readdata !== mdl[1]) begin errors++; $display("FAIL alt_idata c=%0d got %h exp %h", c, i_readdata, mdl[1]); end
                if (c >= 7) begin
                    checks++; if (d_readdata !== mdl[2]) begin errors++; $display("FAIL alt_ddata c=%0d got %h exp %h", c, d_readdata, mdl[2]); end
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        int nw;
        nw = 0;
        do_reset();
        d_write = 1'b1; d_address = 32'h0000_003C; d_writedata = 32'h1234_5678; d_byteenable = 4'hF;
        @(negedge clk); if (m_write === 1'b1) nw++;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        if (m_write === 1'b1) nw++;
        checks++; if (d_waitrequest !== 1'b1 || m_address !== 32'h0 || m_byteenable !== 4'h0) begin errors++; $display("FAIL rstw_outs got %b/%h/%h exp 1/0/0", d_waitrequest, m_address, m_byteenable); end
        @(posedge clk); #1 reset = 1'b0; d_write = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); if (m_write === 1'b1) nw++;
            @(posedge clk); #1;
        end
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin i_read = 1'b1; i_address = 32'h0000_0014; end
            if (c == 4) i_read = 1'b0;
            @(negedge clk);
            if (m_write === 1'b1) nw++;
            checks++; if (i_waitrequest !== (c != 3)) begin errors++; $display("FAIL rstw_iwait c=%0d got %b exp %b", c, i_waitrequest, (c != 3)); end
            @(posedge clk); #1;
        end
        checks++; if (nw !== 0) begin errors++; $display("FAIL rstw_nowrite got %0d exp 0", nw); end
        checks++; if (ram[15] !== mdl[15]) begin errors++; $display("FAIL rstw_ram got %h exp %h", ram[15], mdl[15]); end
    endtask

    task automatic test_drop();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin d_read = 1'b1; d_address = 32'h0000_0010; d_byteenable = 4'hF; end
            if (c == 1) d_read = 1'b0;
            if (c == 2) begin i_read = 1'b1; i_address = 32'h0000_0020; end
            if (c == 6) i_read = 1'b0;
            @(negedge clk);
            checks++; if (d_waitrequest !== 1'b1 || m_write !== 1'b0) begin errors++; $display("FAIL drop_d c=%0d got %b/%b exp 1/0", c, d_waitrequest, m_write); end
            checks++; if (i_waitrequest !== (c != 5)) begin errors++; $display("FAIL drop_i c=%0d got %b exp %b", c, i_waitrequest, (c != 5)); end
            if (c == 1) begin
                checks++; if (m_read !== 1'b0) begin errors++; $display("FAIL drop_mread got %b exp 0", m_read); end
            end
            @(posedge clk); #1;
        end
    endtask

    // Transaction-level reference: a request seen while the bus is free is served
    // at once, finishes 1+LAT cycles later, and the bus is free again one cycle after.
    task automatic test_random();
        bit ip, dp, dw, win, last, act, idn, ddn;
        int free_c, st_c, dn_c, k;
        logic [31:0] ia, da, dd, ih, dh;
        logic [3:0] dbe;
        ip = 0; dp = 0; dw = 0; win = 0; last = 1; free_c = 0; st_c = -100; dn_c = -100;
        ia = 0; da = 0; dd = 0; dbe = 0; ih = 0; dh = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1; ia = {$urandom_range(0, 65535), 16'h0} | {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; k = $urandom_range(0, 3); dw = (k >= 2);
                da = {26'h0, 4'($urandom_range(0, 15)), 2'b00}; dd = $urandom; dbe = 4'($urandom_range(1, 15));
                d_read = (k != 2); d_write = dw;
            end
            i_read = ip; i_address = ia;
            if (!dp) begin d_read = 1'b0; d_write = 1'b0; end
            d_address = da; d_writedata = dd; d_byteenable = dbe;
            if (c >= free_c && (ip || dp)) begin
                win = (ip && dp) ? !last : dp;
                st_c = c; dn_c = c + 1 + LAT; free_c = dn_c + 1;
            end
            act = (c > st_c) && (c <= dn_c);
            idn = (c == dn_c) && !win;
            ddn = (c == dn_c) && win;
            if (idn) begin ih = mdl[ia[5:2]]; last = 0; end
            if (ddn) begin
                last = 1;
                if (dw) mdl[da[5:2]] = merge(mdl[da[5:2]], dd, dbe);
                else dh = mdl[da[5:2]];
            end
            @(negedge clk);
            checks++; if (i_waitrequest !== !idn || d_waitrequest !== !ddn) begin errors++; $display("FAIL rnd_wait c=%0d got %b%b exp %b%b", c, i_waitrequest, d_waitrequest, !idn, !ddn); end
            checks++; if (m_write !== (ddn && dw)) begin errors++; $display("FAIL rnd_mwrite c=%0d got %b exp %b", c, m_write, (ddn && dw)); end
            checks++; if (m_read !== (act && (!win || !dw))) begin errors++; $display("FAIL rnd_mread c=%0d got %b exp %b", c, m_read, (act && (!win || !dw))); end
            checks++; if (m_address !== (act ? (win ? da : ia) : 32'h0)) begin errors++; $display("FAIL rnd_maddr c=%0d got %h exp %h", c, m_address, (act ? (win ? da : ia) : 32'h0)); end
            checks++; if (i_readdata !== ih || d_readdata !== dh) begin errors++; $display("FAIL rnd_rdata c=%0d got %h/%h exp %h/%h", c, i_readdata, d_readdata, ih, dh); end
            if (ddn && dw) begin
                checks++; if (m_writedata !== dd || m_byteenable !== dbe) begin errors++; $display("FAIL rnd_wbus c=%0d got %h/%h exp %h/%h", c, m_writedata, m_byteenable, dd, dbe); end
            end
            if (idn) ip = 0;
            if (ddn) dp = 0;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = INIT[i];
        idle_inputs();
        reset = 1'b1;
        test_fetch();
        test_reset();
        test_tie_write();
        test_alternate();
        test_reset_in_wait();
        test_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
